// File: rtl/branch_resolver_pkg.sv
// Shared definitions for the branch resolver: opcode map (ALU/load and
// branch opcodes), FSM state encoding, address width, and opcode
// classification helpers used by the resolver and its condition evaluator.
package branch_resolver_pkg;

   localparam int ADDR_W = 10;
   localparam int OP_W   = 6;

   // ALU / load opcodes
   localparam logic [OP_W-1:0] OP_NOP   = 6'h00;
   localparam logic [OP_W-1:0] OP_ADDA  = 6'h01;
   localparam logic [OP_W-1:0] OP_ADDB  = 6'h02;
   localparam logic [OP_W-1:0] OP_ADDCA = 6'h03;
   localparam logic [OP_W-1:0] OP_ADDCB = 6'h04;
   localparam logic [OP_W-1:0] OP_ANDA  = 6'h05;
   localparam logic [OP_W-1:0] OP_ANDB  = 6'h06;
   localparam logic [OP_W-1:0] OP_ANDCA = 6'h07;
   localparam logic [OP_W-1:0] OP_ANDCB = 6'h08;
   localparam logic [OP_W-1:0] OP_ORA   = 6'h09;
   localparam logic [OP_W-1:0] OP_ORB   = 6'h0A;
   localparam logic [OP_W-1:0] OP_ORCA  = 6'h0B;
   localparam logic [OP_W-1:0] OP_ORCB  = 6'h0C;
   localparam logic [OP_W-1:0] OP_ASLA  = 6'h0D;
   localparam logic [OP_W-1:0] OP_ASRA  = 6'h0E;
   localparam logic [OP_W-1:0] OP_SUBA  = 6'h0F;
   localparam logic [OP_W-1:0] OP_SUBB  = 6'h10;
   localparam logic [OP_W-1:0] OP_SUBCA = 6'h11;
   localparam logic [OP_W-1:0] OP_SUBCB = 6'h12;
   localparam logic [OP_W-1:0] OP_LDA   = 6'h13;
   localparam logic [OP_W-1:0] OP_LDB   = 6'h14;
   localparam logic [OP_W-1:0] OP_LDCA  = 6'h15;
   localparam logic [OP_W-1:0] OP_LDCB  = 6'h16;
   localparam logic [OP_W-1:0] OP_STA   = 6'h17;
   localparam logic [OP_W-1:0] OP_STB   = 6'h18;

   // Branch opcodes
   localparam logic [OP_W-1:0] OP_BAEQ  = 6'h20;
   localparam logic [OP_W-1:0] OP_BANE  = 6'h21;
   localparam logic [OP_W-1:0] OP_BACS  = 6'h22;
   localparam logic [OP_W-1:0] OP_BACC  = 6'h23;
   localparam logic [OP_W-1:0] OP_BAMI  = 6'h24;
   localparam logic [OP_W-1:0] OP_BAPL  = 6'h25;
   localparam logic [OP_W-1:0] OP_BBEQ  = 6'h28;
   localparam logic [OP_W-1:0] OP_BBNE  = 6'h29;
   localparam logic [OP_W-1:0] OP_BBCS  = 6'h2A;
   localparam logic [OP_W-1:0] OP_BBCC  = 6'h2B;
   localparam logic [OP_W-1:0] OP_BBMI  = 6'h2C;
   localparam logic [OP_W-1:0] OP_BBPL  = 6'h2D;
   localparam logic [OP_W-1:0] OP_JMP   = 6'h30;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_FLAGS = 2'd1,
      REDIRECT   = 2'd2
   } br_state_t;

   // True for any conditional branch or JMP
   function automatic logic is_branch_op(input logic [OP_W-1:0] op);
      logic r;
      case (op)
         OP_BAEQ, OP_BANE, OP_BACS, OP_BACC, OP_BAMI, OP_BAPL,
         OP_BBEQ, OP_BBNE, OP_BBCS, OP_BBCC, OP_BBMI, OP_BBPL,
         OP_JMP:  r = 1'b1;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   // True when the opcode updates register A (and hence A's flags)
   function automatic logic is_a_writer(input logic [OP_W-1:0] op);
      logic r;
      case (op)
         OP_ADDA, OP_ADDCA, OP_ANDA, OP_ANDCA, OP_ORA, OP_ORCA,
         OP_ASLA, OP_ASRA, OP_SUBA, OP_SUBCA, OP_LDA, OP_LDCA:
                  r = 1'b1;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   // True when the opcode updates register B (and hence B's flags)
   function automatic logic is_b_writer(input logic [OP_W-1:0] op);
      logic r;
      case (op)
         OP_ADDB, OP_ADDCB, OP_ANDB, OP_ANDCB, OP_ORB, OP_ORCB,
         OP_SUBB, OP_SUBCB, OP_LDB, OP_LDCB:
                  r = 1'b1;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluator: decodes a branch opcode against
// the committed A/B flags and reports whether it is taken and which register
// side's flags it depends on. JMP is always taken and reads neither side.
module branch_cond_eval
   import branch_resolver_pkg::*;
(
   input  logic [OP_W-1:0] i_opcode,
   input  logic            i_ca,
   input  logic            i_cb,
   input  logic            i_za,
   input  logic            i_zb,
   input  logic            i_na,
   input  logic            i_nb,
   output logic            o_taken,
   output logic            o_reads_a,
   output logic            o_reads_b
);

   // Decode opcode into taken/read-side using the six flags
   always_comb begin
      o_taken   = 1'b0;
      o_reads_a = 1'b0;
      o_reads_b = 1'b0;
      case (i_opcode)
         OP_BAEQ: begin o_reads_a = 1'b1; o_taken = i_za;  end
         OP_BANE: begin o_reads_a = 1'b1; o_taken = ~i_za; end
         OP_BACS: begin o_reads_a = 1'b1; o_taken = i_ca;  end
         OP_BACC: begin o_reads_a = 1'b1; o_taken = ~i_ca; end
         OP_BAMI: begin o_reads_a = 1'b1; o_taken = i_na;  end
         OP_BAPL: begin o_reads_a = 1'b1; o_taken = ~i_na; end
         OP_BBEQ: begin o_reads_b = 1'b1; o_taken = i_zb;  end
         OP_BBNE: begin o_reads_b = 1'b1; o_taken = ~i_zb; end
         OP_BBCS: begin o_reads_b = 1'b1; o_taken = i_cb;  end
         OP_BBCC: begin o_reads_b = 1'b1; o_taken = ~i_cb; end
         OP_BBMI: begin o_reads_b = 1'b1; o_taken = i_nb;  end
         OP_BBPL: begin o_reads_b = 1'b1; o_taken = ~i_nb; end
         OP_JMP:  begin o_taken = 1'b1; end
         default: begin o_taken = 1'b0; end
      endcase
   end

endmodule

// File: rtl/branch_resolver.sv
// Branch resolver: classifies the decode-stage instruction, detects a flag
// hazard against the instruction in execute, and drives stall / redirect /
// flush through a three-state FSM (IDLE, WAIT_FLAGS, REDIRECT).
// Optional feature macro: BRANCH_STATS_EN adds branch_count / taken_count.
module branch_resolver
   import branch_resolver_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic [OP_W-1:0]   id_instruction,
   input  logic              id_valid,
   input  logic [ADDR_W-1:0] id_target,
   input  logic [OP_W-1:0]   ex_instruction,
   input  logic              ex_valid,
   input  logic              CA,
   input  logic              CB,
   input  logic              ZA,
   input  logic              ZB,
   input  logic              NA,
   input  logic              NB,
   output logic              take_branch,
   output logic [ADDR_W-1:0] branch_target,
   output logic              stall,
   output logic              flush
`ifdef BRANCH_STATS_EN
   ,
   output logic [15:0]       branch_count,
   output logic [15:0]       taken_count
`endif
);

   br_state_t           r_state;
   br_state_t           w_next_state;
   logic [OP_W-1:0]     r_pend_op;
   logic [ADDR_W-1:0]   r_pend_target;
   logic [ADDR_W-1:0]   r_branch_target;
   logic                r_take_branch;
   logic                r_flush;

   logic [OP_W-1:0]     w_eval_op;
   logic [ADDR_W-1:0]   w_target_src;
   logic                w_taken;
   logic                w_reads_a;
   logic                w_reads_b;
   logic                w_id_is_branch;
   logic                w_hazard;
   logic                w_stall;
   logic                w_pend_load;
   logic                w_load_target;
   logic                w_resolved;

   // While waiting for flags, the held branch is evaluated from its latched copy
   assign w_eval_op    = (r_state == WAIT_FLAGS) ? r_pend_op : id_instruction;
   assign w_target_src = (r_state == WAIT_FLAGS) ? r_pend_target : id_target;

   assign w_id_is_branch = id_valid & is_branch_op(id_instruction);
   assign w_hazard = w_id_is_branch & ex_valid &
                     ((w_reads_a & is_a_writer(ex_instruction)) |
                      (w_reads_b & is_b_writer(ex_instruction)));

   branch_cond_eval u_cond (
      .i_opcode  (w_eval_op),
      .i_ca      (CA),
      .i_cb      (CB),
      .i_za      (ZA),
      .i_zb      (ZB),
      .i_na      (NA),
      .i_nb      (NB),
      .o_taken   (w_taken),
      .o_reads_a (w_reads_a),
      .o_reads_b (w_reads_b)
   );

   // Next-state and per-cycle control decode
   always_comb begin
      w_next_state  = r_state;
      w_stall       = 1'b0;
      w_pend_load   = 1'b0;
      w_load_target = 1'b0;
      w_resolved    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_id_is_branch) begin
               if (w_hazard) begin
                  w_stall      = 1'b1;
                  w_pend_load  = 1'b1;
                  w_next_state = WAIT_FLAGS;
               end else begin
                  w_resolved = 1'b1;
                  if (w_taken) begin
                     w_load_target = 1'b1;
                     w_next_state  = REDIRECT;
                  end else begin
                     w_next_state = IDLE;
                  end
               end
            end else begin
               w_next_state = IDLE;
            end
         end
         WAIT_FLAGS: begin
            w_resolved = 1'b1;
            if (w_taken) begin
               w_load_target = 1'b1;
               w_next_state  = REDIRECT;
            end else begin
               w_next_state = IDLE;
            end
         end
         REDIRECT: begin
            // Decode instruction is being flushed; ignore it
            w_next_state = IDLE;
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   // State, redirect outputs and redirect target registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state         <= IDLE;
         r_take_branch   <= 1'b0;
         r_flush         <= 1'b0;
         r_branch_target <= {ADDR_W{1'b0}};
      end else begin
         r_state       <= w_next_state;
         r_take_branch <= (w_next_state == REDIRECT);
         r_flush       <= (w_next_state == REDIRECT);
         if (w_load_target) begin
            r_branch_target <= w_target_src;
         end
      end
   end

   // Capture the stalled branch so it can be re-evaluated once flags settle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pend_op     <= OP_NOP;
         r_pend_target <= {ADDR_W{1'b0}};
      end else if (w_pend_load) begin
         r_pend_op     <= id_instruction;
         r_pend_target <= id_target;
      end
   end

   assign take_branch   = r_take_branch;
   assign flush         = r_flush;
   assign branch_target = r_branch_target;
   assign stall         = w_stall;

`ifdef BRANCH_STATS_EN
   logic [15:0] r_branch_count;
   logic [15:0] r_taken_count;

   // Resolved-branch and redirect-entry counters, wrapping at 16 bits
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_branch_count <= 16'd0;
         r_taken_count  <= 16'd0;
      end else begin
         if (w_resolved) begin
            r_branch_count <= r_branch_count + 16'd1;
         end
         if (w_load_target) begin
            r_taken_count <= r_taken_count + 16'd1;
         end
      end
   end

   assign branch_count = r_branch_count;
   assign taken_count  = r_taken_count;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Directed self-checking bench for branch_resolver. Inputs change 1 time unit
// after a rising edge; combinational stall is checked 1 unit later, and
// registered outputs are checked 1 unit after the following rising edge.
module tb_branch_resolver;
   import branch_resolver_pkg::*;

   logic              clk;
   logic              reset_n;
   logic [OP_W-1:0]   id_instruction;
   logic              id_valid;
   logic [ADDR_W-1:0] id_target;
   logic [OP_W-1:0]   ex_instruction;
   logic              ex_valid;
   logic              CA, CB, ZA, ZB, NA, NB;
   logic              take_branch;
   logic [ADDR_W-1:0] branch_target;
   logic              stall;
   logic              flush;
`ifdef BRANCH_STATS_EN
   logic [15:0]       branch_count;
   logic [15:0]       taken_count;
`endif

   int checks   = 0;
   int failures = 0;

   branch_resolver dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .id_instruction (id_instruction),
      .id_valid       (id_valid),
      .id_target      (id_target),
      .ex_instruction (ex_instruction),
      .ex_valid       (ex_valid),
      .CA             (CA),
      .CB             (CB),
      .ZA             (ZA),
      .ZB             (ZB),
      .NA             (NA),
      .NB             (NB),
      .take_branch    (take_branch),
      .branch_target  (branch_target),
      .stall          (stall),
      .flush          (flush)
`ifdef BRANCH_STATS_EN
      ,
      .branch_count   (branch_count),
      .taken_count    (taken_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic [OP_W-1:0] op, input logic v, input logic [ADDR_W-1:0] tgt);
      id_instruction = op;
      id_valid       = v;
      id_target      = tgt;
   endtask

   task automatic set_ex(input logic [OP_W-1:0] op, input logic v);
      ex_instruction = op;
      ex_valid       = v;
   endtask

   task automatic chk_out(input string tag, input logic tb, input logic fl, input logic [ADDR_W-1:0] tgt);
      check({tag, "_take"},   {15'd0, take_branch}, {15'd0, tb});
      check({tag, "_flush"},  {15'd0, flush},       {15'd0, fl});
      check({tag, "_target"}, {6'd0, branch_target}, {6'd0, tgt});
   endtask

   initial begin
      reset_n = 1'b0;
      set_id(OP_NOP, 1'b0, 10'd0);
      set_ex(OP_NOP, 1'b0);
      {CA, CB, ZA, ZB, NA, NB} = 6'b000000;
      #2;
      chk_out("reset", 1'b0, 1'b0, 10'h000);
      check("reset_stall", {15'd0, stall}, 16'd0);
      step();
      step();
      reset_n = 1'b1;
      step();

      // Hazard-free taken BAEQ: redirect next cycle, then one cycle only
      ZA = 1'b1;
      set_ex(OP_NOP, 1'b1);
      set_id(OP_BAEQ, 1'b1, 10'h05A);
      #1 check("baeq_nostall", {15'd0, stall}, 16'd0);
      step();
      chk_out("baeq_redir", 1'b1, 1'b1, 10'h05A);
      set_id(OP_NOP, 1'b1, 10'h000);
      step();
      chk_out("baeq_after", 1'b0, 1'b0, 10'h05A);

      // Hazard on A: stall one cycle, then flags update ZA=1 -> redirect
      ZA = 1'b0;
      set_ex(OP_ADDA, 1'b1);
      set_id(OP_BAEQ, 1'b1, 10'h100);
      #1 check("haz_a_stall", {15'd0, stall}, 16'd1);
      step();
      set_ex(OP_NOP, 1'b0);
      ZA = 1'b1;
      #1 check("haz_a_wait_stall", {15'd0, stall}, 16'd0);
      chk_out("haz_a_wait", 1'b0, 1'b0, 10'h05A);
      step();
      chk_out("haz_a_redir", 1'b1, 1'b1, 10'h100);
      set_id(OP_NOP, 1'b1, 10'h000);
      step();
      chk_out("haz_a_after", 1'b0, 1'b0, 10'h100);

      // Hazard on A, flags resolve ZA=0 -> no redirect
      ZA = 1'b1;
      set_ex(OP_SUBCA, 1'b1);
      set_id(OP_BAEQ, 1'b1, 10'h155);
      #1 check("haz_a0_stall", {15'd0, stall}, 16'd1);
      step();
      set_ex(OP_NOP, 1'b0);
      ZA = 1'b0;
      #1 check("haz_a0_wait_stall", {15'd0, stall}, 16'd0);
      step();
      chk_out("haz_a0_none", 1'b0, 1'b0, 10'h100);
      set_id(OP_NOP, 1'b1, 10'h000);
      step();
      chk_out("haz_a0_idle", 1'b0, 1'b0, 10'h100);

      // B-writer in EX, A-side branch: no stall; CA=0 so BACS not taken
      CA = 1'b0;
      set_ex(OP_SUBB, 1'b1);
      set_id(OP_BACS, 1'b1, 10'h2AA);
      #1 check("bacs_nostall", {15'd0, stall}, 16'd0);
      step();
      chk_out("bacs_nottaken", 1'b0, 1'b0, 10'h100);
      set_id(OP_NOP, 1'b1, 10'h000);

      // Invalid decode slot or invalid EX never stalls
      set_ex(OP_ADDA, 1'b1);
      set_id(OP_BAEQ, 1'b0, 10'h0F0);
      #1 check("idinv_nostall", {15'd0, stall}, 16'd0);
      set_ex(OP_ADDA, 1'b0);
      set_id(OP_BANE, 1'b1, 10'h0F0);
      ZA = 1'b1;
      #1 check("exinv_nostall", {15'd0, stall}, 16'd0);
      step();
      chk_out("bane_nottaken", 1'b0, 1'b0, 10'h100);

      // Cross-side: A-writer does not hazard a B branch; NB=0 -> BBMI not taken
      NB = 1'b0;
      set_ex(OP_LDCA, 1'b1);
      set_id(OP_BBMI, 1'b1, 10'h0AB);
      #1 check("bbmi_cross_nostall", {15'd0, stall}, 16'd0);
      step();
      chk_out("bbmi_nottaken", 1'b0, 1'b0, 10'h100);

      // B hazard: LDB in EX stalls BBMI; NB=1 afterwards -> redirect
      set_ex(OP_LDB, 1'b1);
      set_id(OP_BBMI, 1'b1, 10'h2C7);
      #1 check("haz_b_stall", {15'd0, stall}, 16'd1);
      step();
      set_ex(OP_NOP, 1'b0);
      NB = 1'b1;
      step();
      chk_out("haz_b_redir", 1'b1, 1'b1, 10'h2C7);
      set_id(OP_NOP, 1'b1, 10'h000);
      step();

      // JMP with A-writer in EX: no stall, redirect; BBNE during REDIRECT ignored
      ZB = 1'b0;
      set_ex(OP_LDA, 1'b1);
      set_id(OP_JMP, 1'b1, 10'h3FF);
      #1 check("jmp_nostall", {15'd0, stall}, 16'd0);
      step();
      chk_out("jmp_redir", 1'b1, 1'b1, 10'h3FF);
      set_ex(OP_LDB, 1'b1);
      set_id(OP_BBNE, 1'b1, 10'h011);
      #1 check("redir_ignore_stall", {15'd0, stall}, 16'd0);
      step();
      chk_out("redir_ignored", 1'b0, 1'b0, 10'h3FF);
      set_ex(OP_NOP, 1'b0);
      set_id(OP_NOP, 1'b1, 10'h000);
      step();
      chk_out("redir_ignored2", 1'b0, 1'b0, 10'h3FF);

      // Reset during REDIRECT clears outputs immediately
      set_id(OP_JMP, 1'b1, 10'h0C3);
      step();
      chk_out("pre_rst_redir", 1'b1, 1'b1, 10'h0C3);
      reset_n = 1'b0;
      set_id(OP_NOP, 1'b1, 10'h000);
      #1 chk_out("rst_redir", 1'b0, 1'b0, 10'h000);
      step();
      reset_n = 1'b1;
      #1 check("rst_state_idle", {14'd0, dut.r_state}, {14'd0, IDLE});
      step();
      chk_out("post_rst_idle", 1'b0, 1'b0, 10'h000);

      // Reset during WAIT_FLAGS: pending branch must not survive
      ZA = 1'b1;
      set_ex(OP_ASLA, 1'b1);
      set_id(OP_BAEQ, 1'b1, 10'h1E1);
      #1 check("wf_stall", {15'd0, stall}, 16'd1);
      step();
      reset_n = 1'b0;
      set_ex(OP_NOP, 1'b0);
      set_id(OP_NOP, 1'b1, 10'h000);
      #1 check("rst_wf_state", {14'd0, dut.r_state}, {14'd0, IDLE});
      step();
      reset_n = 1'b1;
      step();
      chk_out("rst_wf_none", 1'b0, 1'b0, 10'h000);

      // First branch after reset processed normally
      set_id(OP_JMP, 1'b1, 10'h077);
      step();
      chk_out("first_after_rst", 1'b1, 1'b1, 10'h077);
      set_id(OP_NOP, 1'b1, 10'h000);
      step();

`ifdef BRANCH_STATS_EN
      reset_n = 1'b0;
      #1 check("stat_rst_b", branch_count, 16'd0);
      check("stat_rst_t", taken_count, 16'd0);
      step();
      reset_n = 1'b1;
      step();
      for (int i = 0; i < 3; i++) begin
         set_id(OP_JMP, 1'b1, 10'h010);
         step();
         set_id(OP_NOP, 1'b1, 10'h000);
         step();
      end
      ZA = 1'b0;
      set_ex(OP_NOP, 1'b0);
      set_id(OP_BAEQ, 1'b1, 10'h020);
      step();
      step();
      set_id(OP_NOP, 1'b1, 10'h000);
      step();
      check("stat_branch5", branch_count, 16'd5);
      check("stat_taken3", taken_count, 16'd3);
      set_id(OP_BAEQ, 1'b1, 10'h020);
      repeat (65530) @(posedge clk);
      #1 check("stat_ffff", branch_count, 16'hFFFF);
      step();
      check("stat_wrap", branch_count, 16'd0);
      set_id(OP_NOP, 1'b1, 10'h000);
      step();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
